// File: rtl/ppu_render_scheduler.sv
// ppu_render_scheduler
// Dot/scanline timing controller for the PPU. It counts dots and scanlines
// and decodes the (line, dot) positions that sequence the VRAM address
// datapath in the register block. It also owns the vblank status flag, NMI
// generation and the sprite-flag clear. All outputs are registered.
//
// Ports
//   clk                 system clock, everything on posedge
//   rst                 asynchronous, active-high reset
//   dot_EN              pixel-clock enable; counters advance only when high
//   rendering_EN        background_EN | sprite_EN
//   interrupt_EN        NMI enable from the control register
//   clearVerticalBlank  one-cycle pulse, CPU read of the status register
//   incrementX          strobe: coarse X / page X increment
//   incrementY          strobe: fine/coarse Y increment
//   resetX              strobe: copy temp X bits into the VRAM address
//   resetY              strobe: copy temp Y bits into the VRAM address
//   clearSpriteFlags    strobe: clear spriteCollision and spriteOverflow
//   verticalBlankRegion vblank status flag (level)
//   nmi                 NMI request (level)
//   dot, scanline       current counters
//   oddFrame            frame parity
module ppu_render_scheduler #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VISIBLE_LINES   = 240,
    parameter int VBLANK_LINE     = 241
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dot_EN,
    input  logic       rendering_EN,
    input  logic       interrupt_EN,
    input  logic       clearVerticalBlank,
    output logic       incrementX,
    output logic       incrementY,
    output logic       resetX,
    output logic       resetY,
    output logic       clearSpriteFlags,
    output logic       verticalBlankRegion,
    output logic       nmi,
    output logic [8:0] dot,
    output logic [8:0] scanline,
    output logic       oddFrame
);

    localparam logic [8:0] LAST_DOT   = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] SKIP_DOT   = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] PRE_LINE   = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] VIS_LINES  = 9'(VISIBLE_LINES);
    localparam logic [8:0] VBL_LINE   = 9'(VBLANK_LINE);
    localparam logic [8:0] FLAG_DOT   = 9'd1;
    localparam logic [8:0] X_FIRST    = 9'd8;
    localparam logic [8:0] X_LAST     = 9'd256;
    localparam logic [8:0] X_FETCH_A  = 9'd328;
    localparam logic [8:0] X_FETCH_B  = 9'd336;
    localparam logic [8:0] Y_DOT      = 9'd256;
    localparam logic [8:0] RX_DOT     = 9'd257;
    localparam logic [8:0] RY_FIRST   = 9'd280;
    localparam logic [8:0] RY_LAST    = 9'd304;

    logic [8:0] dot_r;
    logic [8:0] scanline_r;
    logic       odd_frame_r;
    logic       inc_x_r;
    logic       inc_y_r;
    logic       reset_x_r;
    logic       reset_y_r;
    logic       clear_sprite_r;
    logic       vblank_r;
    logic       nmi_r;

    logic [8:0] dot_next_s;
    logic [8:0] scanline_next_s;
    logic       odd_frame_next_s;
    logic       inc_x_s;
    logic       inc_y_s;
    logic       reset_x_s;
    logic       reset_y_s;
    logic       clear_sprite_s;
    logic       vblank_next_s;
    logic       render_line_s;
    logic       pre_line_s;
    logic       render_active_s;

    assign pre_line_s      = (scanline_r == PRE_LINE);
    assign render_line_s   = (scanline_r < VIS_LINES) || pre_line_s;
    assign render_active_s = rendering_EN && render_line_s;

    // Event decode and next-state for counters and vblank flag
    always_comb begin
        dot_next_s       = dot_r;
        scanline_next_s  = scanline_r;
        odd_frame_next_s = odd_frame_r;
        inc_x_s          = 1'b0;
        inc_y_s          = 1'b0;
        reset_x_s        = 1'b0;
        reset_y_s        = 1'b0;
        clear_sprite_s   = 1'b0;
        vblank_next_s    = vblank_r;

        if (dot_EN) begin
            // Tile fetch increments every 8 dots across the visible span,
            // plus the two prefetch tiles for the next line.
            inc_x_s = render_active_s &&
                      (((dot_r[2:0] == 3'd0) && (dot_r >= X_FIRST) && (dot_r <= X_LAST)) ||
                       (dot_r == X_FETCH_A) || (dot_r == X_FETCH_B));
            inc_y_s   = render_active_s && (dot_r == Y_DOT);
            reset_x_s = render_active_s && (dot_r == RX_DOT);
            reset_y_s = rendering_EN && pre_line_s &&
                        (dot_r >= RY_FIRST) && (dot_r <= RY_LAST);
            clear_sprite_s = pre_line_s && (dot_r == FLAG_DOT);

            if (pre_line_s && odd_frame_r && rendering_EN && (dot_r == SKIP_DOT)) begin
                // Short odd frame: the last dot of the pre-render line is dropped.
                dot_next_s       = 9'd0;
                scanline_next_s  = 9'd0;
                odd_frame_next_s = ~odd_frame_r;
            end else if (dot_r == LAST_DOT) begin
                dot_next_s = 9'd0;
                if (pre_line_s) begin
                    scanline_next_s  = 9'd0;
                    odd_frame_next_s = ~odd_frame_r;
                end else begin
                    scanline_next_s = scanline_r + 9'd1;
                end
            end else begin
                dot_next_s = dot_r + 9'd1;
            end
        end else begin
            dot_next_s = dot_r;
        end

        // A CPU status read wins over a coincident set, suppressing the
        // flag (and therefore the NMI) for the whole frame.
        if (clearVerticalBlank) begin
            vblank_next_s = 1'b0;
        end else if (dot_EN && (scanline_r == VBL_LINE) && (dot_r == FLAG_DOT)) begin
            vblank_next_s = 1'b1;
        end else if (dot_EN && pre_line_s && (dot_r == FLAG_DOT)) begin
            vblank_next_s = 1'b0;
        end else begin
            vblank_next_s = vblank_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_r          <= 9'd0;
            scanline_r     <= 9'd0;
            odd_frame_r    <= 1'b0;
            inc_x_r        <= 1'b0;
            inc_y_r        <= 1'b0;
            reset_x_r      <= 1'b0;
            reset_y_r      <= 1'b0;
            clear_sprite_r <= 1'b0;
            vblank_r       <= 1'b0;
            nmi_r          <= 1'b0;
        end else begin
            dot_r          <= dot_next_s;
            scanline_r     <= scanline_next_s;
            odd_frame_r    <= odd_frame_next_s;
            inc_x_r        <= inc_x_s;
            inc_y_r        <= inc_y_s;
            reset_x_r      <= reset_x_s;
            reset_y_r      <= reset_y_s;
            clear_sprite_r <= clear_sprite_s;
            vblank_r       <= vblank_next_s;
            // Built from the next flag value so nmi moves in the same clk as vblank.
            nmi_r          <= vblank_next_s && interrupt_EN;
        end
    end

    assign incrementX          = inc_x_r;
    assign incrementY          = inc_y_r;
    assign resetX              = reset_x_r;
    assign resetY              = reset_y_r;
    assign clearSpriteFlags    = clear_sprite_r;
    assign verticalBlankRegion = vblank_r;
    assign nmi                 = nmi_r;
    assign dot                 = dot_r;
    assign scanline            = scanline_r;
    assign oddFrame            = odd_frame_r;

endmodule
